// File: rtl/slave_fifo_responder.sv
// Slave-FIFO responder: OUT endpoint (host push, slave pop) and IN endpoint with page/PKTEND commit.
// Optional FRAME_CHECK_EN macro adds a prefix/header/payload monitor on accepted IN words.
`ifndef PREFIX
`define PREFIX 16'hA55A
`endif

module slave_fifo_responder #(
    parameter int DEPTH_LOG2 = 9,
    parameter int PAGE_WORDS = 256
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [15:0] FD,
    input  logic        SLOE,
    input  logic        SLRD,
    input  logic        SLWR,
    input  logic [1:0]  FIFOADR,
    input  logic        PKTEND,
    output logic        FLAG_EMPTY,
    output logic        FLAG_FULL,
    input  logic [15:0] H_OUT_DATA,
    input  logic        H_OUT_WR,
    output logic        H_OUT_FULL,
    input  logic        H_IN_RD,
    output logic [15:0] H_IN_DATA,
    output logic        H_IN_EMPTY,
    output logic [15:0] PKT_CNT,
    output logic        OVF,
    output logic        UNF,
    output logic [7:0]  FRAME_ERR_CNT
);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   PAGE_CNT = PAGE_WORDS[DEPTH_LOG2:0];

    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_COMMIT} commit_state_t;

    logic [15:0]           r_out_mem [1<<DEPTH_LOG2];
    logic [15:0]           r_in_mem  [1<<DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] r_out_wptr, r_out_rptr, r_in_wptr, r_in_rptr;
    logic [DEPTH_LOG2:0]   r_out_cnt, r_in_ccnt, r_in_ucnt;
    logic                  r_flag_empty, r_flag_full, r_ovf, r_unf;
    logic [15:0]           r_pkt_cnt;
    commit_state_t         r_state;

    logic                  w_out_sel, w_in_sel, w_out_full, w_in_full, w_commit, w_close;
    logic                  w_out_push, w_out_pop, w_in_wr, w_in_pop;
    logic [DEPTH_LOG2:0]   w_out_cnt_nxt, w_in_total, w_ccnt_nxt, w_ucnt_nxt;

    assign w_out_sel  = (FIFOADR == 2'b00);
    assign w_in_sel   = (FIFOADR == 2'b10);
    assign w_out_full = (r_out_cnt == FULL_CNT);
    assign w_in_total = r_in_ccnt + r_in_ucnt;
    assign w_in_full  = (w_in_total == FULL_CNT);
    assign w_out_push = H_OUT_WR && !w_out_full;
    assign w_out_pop  = SLRD && w_out_sel && (r_out_cnt != '0);
    assign w_in_wr    = SLWR && w_in_sel && !w_in_full;
    assign w_in_pop   = H_IN_RD && (r_in_ccnt != '0);
    assign w_commit   = (r_state == S_COMMIT);
    assign w_close    = PKTEND || (w_ucnt_nxt == PAGE_CNT);

    assign FD         = (SLOE && w_out_sel) ? r_out_mem[r_out_rptr] : 16'hzzzz;
    assign H_OUT_FULL = w_out_full;
    assign H_IN_DATA  = r_in_mem[r_in_rptr];
    assign H_IN_EMPTY = (r_in_ccnt == '0);
    assign FLAG_EMPTY = r_flag_empty;
    assign FLAG_FULL  = r_flag_full;
    assign PKT_CNT    = r_pkt_cnt;
    assign OVF        = r_ovf;
    assign UNF        = r_unf;

    always_comb begin
        w_out_cnt_nxt = r_out_cnt;
        if (w_out_push && !w_out_pop)
            w_out_cnt_nxt = r_out_cnt + CNT_ONE;
        else if (!w_out_push && w_out_pop)
            w_out_cnt_nxt = r_out_cnt - CNT_ONE;
    end

    // A word accepted during COMMIT opens the next packet rather than joining this one.
    always_comb begin
        w_ucnt_nxt = w_commit ? '0 : r_in_ucnt;
        if (w_in_wr)
            w_ucnt_nxt = w_ucnt_nxt + CNT_ONE;
        w_ccnt_nxt = r_in_ccnt;
        if (w_commit)
            w_ccnt_nxt = w_ccnt_nxt + r_in_ucnt;
        if (w_in_pop)
            w_ccnt_nxt = w_ccnt_nxt - CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (w_out_push)
            r_out_mem[r_out_wptr] <= H_OUT_DATA;
        if (w_in_wr)
            r_in_mem[r_in_wptr] <= FD;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_wptr   <= '0;
            r_out_rptr   <= '0;
            r_in_wptr    <= '0;
            r_in_rptr    <= '0;
            r_out_cnt    <= '0;
            r_in_ccnt    <= '0;
            r_in_ucnt    <= '0;
            r_flag_empty <= 1'b1;
            r_flag_full  <= 1'b0;
            r_ovf        <= 1'b0;
            r_unf        <= 1'b0;
            r_pkt_cnt    <= '0;
            r_state      <= S_EMPTY;
        end else begin
            if (w_out_push) r_out_wptr <= r_out_wptr + PTR_ONE;
            if (w_out_pop)  r_out_rptr <= r_out_rptr + PTR_ONE;
            if (w_in_wr)    r_in_wptr  <= r_in_wptr + PTR_ONE;
            if (w_in_pop)   r_in_rptr  <= r_in_rptr + PTR_ONE;
            r_out_cnt    <= w_out_cnt_nxt;
            r_in_ccnt    <= w_ccnt_nxt;
            r_in_ucnt    <= w_ucnt_nxt;
            r_flag_empty <= (w_out_cnt_nxt == '0);
            r_flag_full  <= ((w_ccnt_nxt + w_ucnt_nxt) == FULL_CNT);
            if (SLRD && w_out_sel && (r_out_cnt == '0)) r_unf <= 1'b1;
            if (SLWR && w_in_sel && w_in_full)          r_ovf <= 1'b1;
            case (r_state)
                S_EMPTY:  if (w_in_wr) r_state <= w_close ? S_COMMIT : S_FILL;
                S_FILL:   if (w_close) r_state <= S_COMMIT;
                S_COMMIT: begin
                    r_pkt_cnt <= r_pkt_cnt + 16'd1;
                    r_state   <= w_in_wr ? S_FILL : S_EMPTY;
                end
                default:  r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef FRAME_CHECK_EN
    typedef enum logic [1:0] {M_HUNT, M_HDR, M_PAY} mon_state_t;
    mon_state_t r_mon_state;
    logic [7:0] r_mon_left, r_frame_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mon_state <= M_HUNT;
            r_mon_left  <= '0;
            r_frame_err <= '0;
        end else if (w_in_wr) begin
            case (r_mon_state)
                M_HUNT: begin
                    if (FD == `PREFIX)
                        r_mon_state <= M_HDR;
                    else if (r_frame_err != 8'hFF)
                        r_frame_err <= r_frame_err + 8'd1;
                end
                M_HDR: begin
                    r_mon_left  <= FD[7:0];
                    r_mon_state <= (FD[7:0] == 8'd0) ? M_HUNT : M_PAY;
                end
                M_PAY: begin
                    r_mon_left <= r_mon_left - 8'd1;
                    if (r_mon_left == 8'd1)
                        r_mon_state <= M_HUNT;
                end
                default: r_mon_state <= M_HUNT;
            endcase
        end
    end

    assign FRAME_ERR_CNT = r_frame_err;
`else
    assign FRAME_ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_slave_fifo_responder.sv
// Bench for slave_fifo_responder: vector table, directed corner sequences, randomized queue-model run.
`ifndef PREFIX
`define PREFIX 16'hA55A
`endif

module tb_slave_fifo_responder;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        sloe, slrd, slwr, pktend, h_out_wr, h_in_rd;
    logic [1:0]  fifoadr;
    logic [15:0] h_out_data, fd_drv;
    wire  [15:0] fd;
    wire         fd_oe;
    logic        flag_empty, flag_full, h_out_full, h_in_empty, ovf, unf;
    logic [15:0] h_in_data, pkt_cnt;
    logic [7:0]  frame_err_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 CLK = ~CLK;

    assign fd_oe = !(sloe && fifoadr == 2'b00);
    assign fd    = fd_oe ? fd_drv : 16'hzzzz;

    slave_fifo_responder dut (
        .CLK(CLK), .RST(RST), .FD(fd), .SLOE(sloe), .SLRD(slrd), .SLWR(slwr),
        .FIFOADR(fifoadr), .PKTEND(pktend), .FLAG_EMPTY(flag_empty), .FLAG_FULL(flag_full),
        .H_OUT_DATA(h_out_data), .H_OUT_WR(h_out_wr), .H_OUT_FULL(h_out_full),
        .H_IN_RD(h_in_rd), .H_IN_DATA(h_in_data), .H_IN_EMPTY(h_in_empty),
        .PKT_CNT(pkt_cnt), .OVF(ovf), .UNF(unf), .FRAME_ERR_CNT(frame_err_cnt)
    );

    typedef struct {
        logic        hwr;  logic [15:0] hdat; logic rd; logic wr; logic [15:0] wdat;
        logic        pe;   logic hrd; logic [1:0] adr;
        logic        fe;   logic fdc; logic [15:0] fd; logic unf; logic hie;
        logic        hdc;  logic [15:0] hd; logic [15:0] pkt;
    } vec_t;
    vec_t tbl [18];

    function automatic vec_t mk(input int hwr, hdat, rd, wr, wdat, pe, hrd, adr,
                                input int fe, fdc, fdv, uf, hie, hdc, hd, pkt);
        vec_t v;
        v.hwr = hwr[0]; v.hdat = hdat[15:0]; v.rd = rd[0]; v.wr = wr[0]; v.wdat = wdat[15:0];
        v.pe = pe[0]; v.hrd = hrd[0]; v.adr = adr[1:0]; v.fe = fe[0]; v.fdc = fdc[0];
        v.fd = fdv[15:0]; v.unf = uf[0]; v.hie = hie[0]; v.hdc = hdc[0]; v.hd = hd[15:0];
        v.pkt = pkt[15:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        slrd = 0; slwr = 0; pktend = 0; h_out_wr = 0; h_in_rd = 0;
    endtask

    task automatic do_reset();
        idle();
        #3 RST = 0;
        #10 RST = 1;
        tick();
    endtask

    // Behavioural reference: plain queues for OUT, committed IN and open packet.
    logic [15:0] m_out[$], m_c[$], m_u[$];
    logic [15:0] m_pkt;
    logic        m_ovf, m_unf, m_commit;

    task automatic model_step();
        logic o_pop, o_push, i_pop, i_wr, was_commit;
        o_pop  = slrd && fifoadr == 2'b00 && m_out.size() != 0;
        o_push = h_out_wr && m_out.size() != 512;
        i_pop  = h_in_rd && m_c.size() != 0;
        i_wr   = slwr && fifoadr == 2'b10 && (m_c.size() + m_u.size()) != 512;
        if (slrd && fifoadr == 2'b00 && m_out.size() == 0) m_unf = 1;
        if (slwr && fifoadr == 2'b10 && (m_c.size() + m_u.size()) == 512) m_ovf = 1;
        if (o_pop)  void'(m_out.pop_front());
        if (o_push) m_out.push_back(h_out_data);
        if (i_pop)  void'(m_c.pop_front());
        was_commit = m_commit;
        if (m_commit) begin
            foreach (m_u[k]) m_c.push_back(m_u[k]);
            m_u.delete();
            m_pkt++;
            m_commit = 0;
        end
        if (i_wr) m_u.push_back(fd_drv);
        if (!was_commit && m_u.size() != 0 && (pktend || m_u.size() == 256)) m_commit = 1;
    endtask

    initial begin
        int wpct, rpct, r;
        sloe = 1; fifoadr = 2'b11; fd_drv = 16'h0; h_out_data = 16'h0;
        idle();

        tbl[0]  = mk(1,'h1111,0,0,0,0,0,0,     0,1,'h1111,0,1,0,0,0);
        tbl[1]  = mk(1,'h2222,0,0,0,0,0,0,     0,1,'h1111,0,1,0,0,0);
        tbl[2]  = mk(0,0,1,0,0,0,0,0,          0,1,'h2222,0,1,0,0,0);
        tbl[3]  = mk(0,0,1,0,0,0,0,0,          1,0,0,0,1,0,0,0);
        tbl[4]  = mk(0,0,1,0,0,0,0,0,          1,0,0,1,1,0,0,0);
        tbl[5]  = mk(1,'h3333,1,0,0,0,0,0,     0,1,'h3333,1,1,0,0,0);
        tbl[6]  = mk(1,'h4444,1,0,0,0,0,0,     0,1,'h4444,1,1,0,0,0);
        tbl[7]  = mk(0,0,0,1,'hA001,0,0,2,     0,0,0,1,1,0,0,0);
        tbl[8]  = mk(0,0,0,1,'hA002,0,0,2,     0,0,0,1,1,0,0,0);
        tbl[9]  = mk(0,0,0,1,'hA003,1,0,2,     0,0,0,1,1,0,0,0);
        tbl[10] = mk(0,0,0,0,0,0,0,2,          0,0,0,1,0,1,'hA001,1);
        tbl[11] = mk(0,0,0,0,0,1,0,2,          0,0,0,1,0,1,'hA001,1);
        tbl[12] = mk(0,0,0,0,0,0,0,2,          0,0,0,1,0,1,'hA001,1);
        tbl[13] = mk(0,0,0,0,0,0,1,2,          0,0,0,1,0,1,'hA002,1);
        tbl[14] = mk(0,0,0,0,0,0,1,2,          0,0,0,1,0,1,'hA003,1);
        tbl[15] = mk(0,0,0,0,0,0,1,2,          0,0,0,1,1,0,0,1);
        tbl[16] = mk(0,0,0,0,0,0,1,2,          0,0,0,1,1,0,0,1);
        tbl[17] = mk(0,0,1,0,0,0,0,0,          1,0,0,1,1,0,0,1);

        do_reset();
        chk("reset fe", flag_empty, 1);
        chk("reset ff", flag_full, 0);
        chk("reset hof", h_out_full, 0);
        chk("reset hie", h_in_empty, 1);
        chk("reset pkt", pkt_cnt, 0);
        chk("reset ferr", frame_err_cnt, 0);

        for (int i = 0; i < 18; i++) begin
            h_out_wr = tbl[i].hwr; h_out_data = tbl[i].hdat; slrd = tbl[i].rd;
            slwr = tbl[i].wr; fd_drv = tbl[i].wdat; pktend = tbl[i].pe;
            h_in_rd = tbl[i].hrd; fifoadr = tbl[i].adr;
            tick();
            chk($sformatf("row%0d fe", i), flag_empty, tbl[i].fe);
            chk($sformatf("row%0d unf", i), unf, tbl[i].unf);
            chk($sformatf("row%0d hie", i), h_in_empty, tbl[i].hie);
            chk($sformatf("row%0d pkt", i), pkt_cnt, tbl[i].pkt);
            chk($sformatf("row%0d ff", i), flag_full, 0);
            if (tbl[i].fdc) chk($sformatf("row%0d fd", i), fd, tbl[i].fd);
            if (tbl[i].hdc) chk($sformatf("row%0d hd", i), h_in_data, tbl[i].hd);
        end
        idle();

        // Full page auto-commit
        do_reset();
        fifoadr = 2'b10;
        for (int i = 0; i < 256; i++) begin
            slwr = 1; fd_drv = 16'h1000 + 16'(i);
            tick();
        end
        slwr = 0;
        chk("page pkt pre", pkt_cnt, 0);
        tick();
        chk("page pkt", pkt_cnt, 1);
        chk("page hie", h_in_empty, 0);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("page rd%0d", i), h_in_data, 16'h1000 + 16'(i));
            h_in_rd = 1;
            tick();
        end
        h_in_rd = 0;
        chk("page hie end", h_in_empty, 1);

        // IN overflow at 2^DEPTH_LOG2 words
        do_reset();
        fifoadr = 2'b10;
        for (int i = 1; i <= 513; i++) begin
            slwr = 1; fd_drv = 16'h2000 + 16'(i);
            tick();
            if (i == 511) chk("ovf ff511", flag_full, 0);
            if (i == 512) begin
                chk("ovf ff512", flag_full, 1);
                chk("ovf pre", ovf, 0);
            end
            if (i == 513) chk("ovf set", ovf, 1);
        end
        slwr = 0;
        tick();
        chk("ovf pkt", pkt_cnt, 2);
        for (int i = 1; i <= 512; i++) begin
            chk($sformatf("ovf rd%0d", i), h_in_data, 16'h2000 + 16'(i));
            h_in_rd = 1;
            tick();
        end
        h_in_rd = 0;
        chk("ovf hie end", h_in_empty, 1);
        chk("ovf ff end", flag_full, 0);

        // OUT fill to capacity then drain
        do_reset();
        fifoadr = 2'b00; sloe = 1;
        for (int i = 0; i < 513; i++) begin
            h_out_wr = 1; h_out_data = 16'h5000 + 16'(i);
            tick();
            if (i == 510) chk("hof 511", h_out_full, 0);
            if (i == 511) chk("hof 512", h_out_full, 1);
        end
        h_out_wr = 0;
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("drain fd%0d", i), fd, 16'h5000 + 16'(i));
            slrd = 1;
            tick();
        end
        slrd = 0;
        chk("drain fe", flag_empty, 1);
        chk("drain unf", unf, 0);

        // Asynchronous reset in the middle of a packet
        do_reset();
        fifoadr = 2'b00; slrd = 1; tick(); slrd = 0;
        fifoadr = 2'b10;
        for (int i = 0; i < 3; i++) begin slwr = 1; fd_drv = 16'(i); tick(); end
        slwr = 0; pktend = 1; tick(); pktend = 0; tick();
        for (int i = 0; i < 4; i++) begin slwr = 1; fd_drv = 16'(i); tick(); end
        slwr = 0; h_out_wr = 1; h_out_data = 16'h7777; tick(); h_out_wr = 0;
        chk("mid pkt pre", pkt_cnt, 1);
        chk("mid unf pre", unf, 1);
        RST = 0;
        #2;
        chk("arst fe", flag_empty, 1);
        chk("arst ff", flag_full, 0);
        chk("arst hof", h_out_full, 0);
        chk("arst hie", h_in_empty, 1);
        chk("arst pkt", pkt_cnt, 0);
        chk("arst unf", unf, 0);
        chk("arst ovf", ovf, 0);
        chk("arst ferr", frame_err_cnt, 0);
        #2 RST = 1;
        pktend = 1; tick(); pktend = 0; tick(); tick();
        chk("arst discard pkt", pkt_cnt, 0);
        chk("arst discard hie", h_in_empty, 1);

`ifdef FRAME_CHECK_EN
        do_reset();
        fifoadr = 2'b10;
        for (int i = 0; i < 5; i++) begin
            slwr = 1;
            case (i)
                0: fd_drv = `PREFIX;
                1: fd_drv = 16'h0002;
                2: fd_drv = 16'h000A;
                3: fd_drv = 16'h000B;
                default: fd_drv = 16'h1234;
            endcase
            tick();
            if (i == 3) chk("frame ok", frame_err_cnt, 0);
        end
        slwr = 0;
        chk("frame err", frame_err_cnt, 1);
`endif

        // Randomized run against the queue model
        do_reset();
        m_out.delete(); m_c.delete(); m_u.delete();
        m_pkt = 0; m_ovf = 0; m_unf = 0; m_commit = 0;
        for (int blk = 0; blk < 6; blk++) begin
            wpct = (blk == 0) ? 95 : int'($urandom_range(20, 95));
            rpct = (blk == 0) ? 3  : int'($urandom_range(2, 60));
            for (int cyc = 0; cyc < 1500; cyc++) begin
                r = int'($urandom_range(0, 9));
                fifoadr    = (r < 4) ? 2'b00 : (r < 9) ? 2'b10 : 2'($urandom_range(0, 1) * 2 + 1);
                sloe       = ($urandom_range(0, 3) != 0);
                h_out_wr   = (int'($urandom_range(0, 99)) < wpct);
                h_out_data = 16'($urandom);
                slwr       = (int'($urandom_range(0, 99)) < wpct);
                fd_drv     = 16'($urandom);
                slrd       = (int'($urandom_range(0, 99)) < rpct);
                h_in_rd    = (int'($urandom_range(0, 99)) < rpct);
                pktend     = ($urandom_range(0, 19) == 0);
                model_step();
                tick();
                chk("rnd fe", flag_empty, m_out.size() == 0);
                chk("rnd ff", flag_full, (m_c.size() + m_u.size()) == 512);
                chk("rnd hof", h_out_full, m_out.size() == 512);
                chk("rnd hie", h_in_empty, m_c.size() == 0);
                chk("rnd pkt", pkt_cnt, m_pkt);
                chk("rnd ovf", ovf, m_ovf);
                chk("rnd unf", unf, m_unf);
                if (m_c.size() != 0) chk("rnd hd", h_in_data, m_c[0]);
                if (sloe && fifoadr == 2'b00 && m_out.size() != 0) chk("rnd fd", fd, m_out[0]);
            end
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_fifo_responder.md
SLAVE_FIFO_RESPONDER -- requirements
Module: slave_fifo_responder

Interface
REQ-001 SHALL take parameter DEPTH_LOG2, default 9, log2 of words per endpoint (512).
REQ-002 SHALL take parameter PAGE_WORDS, default 256, words per auto-committed IN packet.
REQ-003 CLK  input  1  clock; all logic on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 FD  inout  16  slave FIFO data bus.
REQ-006 SLOE  input  1  high = responder drives FD.
REQ-007 SLRD  input  1  one-cycle pop strobe, OUT endpoint.
REQ-008 SLWR  input  1  one-cycle push strobe, IN endpoint.
REQ-009 FIFOADR  input  2  endpoint select: 2'b00 = OUT, 2'b10 = IN, others = none.
REQ-010 PKTEND  input  1  one-cycle short-packet commit request.
REQ-011 FLAG_EMPTY  output  1  high = OUT endpoint empty.
REQ-012 FLAG_FULL  output  1  high = IN endpoint full.
REQ-013 H_OUT_DATA / H_OUT_WR / H_OUT_FULL  input 16 / input 1 / output 1  host push into OUT endpoint.
REQ-014 H_IN_RD / H_IN_DATA / H_IN_EMPTY  input 1 / output 16 / output 1  host pop of committed IN words; H_IN_DATA = head word, valid while H_IN_EMPTY = 0.
REQ-015 PKT_CNT  output  16  committed IN packets, wraps at 16'hFFFF.
REQ-016 OVF / UNF  output 1 each  sticky: IN write while full / OUT read while empty.
REQ-017 FRAME_ERR_CNT  output  8  frame errors (see Configuration).

Function
REQ-018 FD SHALL be driven with the OUT head word combinationally iff SLOE=1 and FIFOADR=2'b00; otherwise high-Z.
REQ-019 Edge with SLRD=1, FIFOADR=2'b00, OUT non-empty SHALL pop one word; with OUT empty SHALL pop nothing and set UNF.
REQ-020 Edge with SLWR=1, FIFOADR=2'b10 SHALL capture FD into IN as uncommitted; if IN full (committed+uncommitted = 2^DEPTH_LOG2), word dropped, OVF set.
REQ-021 FLAG_EMPTY/FLAG_FULL SHALL be registered, reflecting occupancy after all operations of the same edge (valid one cycle after strobe).
REQ-022 H_OUT_FULL SHALL be combinational; H_OUT_WR while full drops the word; simultaneous H_OUT_WR and SLRD pop SHALL both take effect.
REQ-023 Commit FSM states: EMPTY (0 uncommitted), FILL (1..PAGE_WORDS-1), COMMIT (one cycle).
REQ-024 EMPTY->FILL on accepted SLWR; FILL->COMMIT when uncommitted reaches PAGE_WORDS or on PKTEND; COMMIT->EMPTY, or ->FILL if a write was accepted during COMMIT.
REQ-025 COMMIT SHALL advance the committed pointer over all uncommitted words and increment PKT_CNT by 1.
REQ-026 PKTEND in EMPTY SHALL be ignored (no zero-length packet); SLWR and PKTEND on the same edge SHALL include that word in the packet.
REQ-027 H_IN_RD with H_IN_EMPTY=0 pops one committed word; with H_IN_EMPTY=1, ignored.
REQ-028 Pointers SHALL wrap modulo 2^DEPTH_LOG2; occupancy counters SHALL be DEPTH_LOG2+1 bits.

Reset
REQ-029 RST low SHALL clear pointers, counters, OVF, UNF, PKT_CNT, FRAME_ERR_CNT, FSM to EMPTY; FLAG_EMPTY=1, FLAG_FULL=0, H_OUT_FULL=0, H_IN_EMPTY=1; FD high-Z unless SLOE=1 and FIFOADR=2'b00.
REQ-030 Reset mid-packet SHALL discard uncommitted and committed data.

Configuration
REQ-031 With FRAME_CHECK_EN defined, a monitor on accepted IN words SHALL expect `PREFIX, then header (length = bits 7:0), then that many payload words, repeating; a non-`PREFIX word where `PREFIX expected increments FRAME_ERR_CNT (saturating at 255) and the monitor stays in prefix-hunt.
REQ-032 Without FRAME_CHECK_EN, FRAME_ERR_CNT SHALL be constant 0 and no monitor logic synthesized.

Verification
REQ-033 Host pushes 16'h1111,16'h2222; SLOE=1, FIFOADR=00, two SLRD pulses -> FD shows 1111 then 2222, FLAG_EMPTY=1 one cycle after second pulse.
REQ-034 256 SLWR pulses with FIFOADR=10 -> commit on 256th, PKT_CNT=1, H_IN_EMPTY=0, host reads 256 words in order.
REQ-035 3 SLWR then PKTEND -> PKT_CNT=1, 3 words visible; extra PKTEND -> PKT_CNT unchanged.
REQ-036 513 SLWR pulses with no host reads -> FLAG_FULL=1 after 512th, 513th dropped, OVF=1.
REQ-037 SLRD with OUT empty -> UNF=1, FLAG_EMPTY stays 1; RST pulse mid-fill -> all outputs at reset values.
REQ-038 FRAME_CHECK_EN: stream `PREFIX,16'h0002,A,B,16'h1234 -> FRAME_ERR_CNT=1.
